// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M raster transmitter.
package d5m_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int CNT_W_DEF  = 12;

   localparam logic [1:0] PAT_RAMP  = 2'd0;
   localparam logic [1:0] PAT_CHECK = 2'd1;
   localparam logic [1:0] PAT_CONST = 2'd2;
   localparam logic [1:0] PAT_BAYER = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      FSTART,
      LINE,
      HBLANK,
      FEND,
      VBLANK
   } state_t;

endpackage

// File: rtl/d5m_pattern_gen.sv
// Combinational test-pattern lookup: maps pixel/line position to a pixel value.
module d5m_pattern_gen
   import d5m_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic [1:0]        pattern,
   input  logic [CNT_W-1:0]  pix,
   input  logic [CNT_W-1:0]  line,
   input  logic [DATA_W-1:0] const_val,
   output logic [DATA_W-1:0] pixel
);

   always_comb begin
      pixel = '0;
      case (pattern)
         PAT_RAMP:  pixel = DATA_W'(pix) + DATA_W'(line);
         PAT_CHECK: pixel = {DATA_W{pix[3] ^ line[3]}};
         PAT_CONST: pixel = const_val;
         // Bayer tag: colour-site bits on top, pixel index underneath
         default:   pixel = {line[0], pix[0], pix[DATA_W-3:0]};
      endcase
   end

endmodule

// File: rtl/d5m_frame_gen.sv
// D5M-style raster transmitter: frame/line sequencing FSM with registered
// camera-bus outputs and a per-frame latched geometry/pattern config.
module d5m_frame_gen
   import d5m_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int P1_CYC = 4,
   parameter int P2_CYC = 4,
   parameter int FCNT_W = 16
) (
   input  logic              pixclk,
   input  logic              reset,
   input  logic              enable,
   input  logic              single_shot,
   input  logic [CNT_W-1:0]  cfg_width,
   input  logic [CNT_W-1:0]  cfg_height,
   input  logic [CNT_W-1:0]  cfg_hblank,
   input  logic [CNT_W-1:0]  cfg_vblank,
   input  logic [1:0]        cfg_pattern,
   input  logic [DATA_W-1:0] cfg_const,
   output logic [DATA_W-1:0] idata,
   output logic              ifval,
   output logic              ilval,
   output logic              frame_start,
   output logic              frame_done,
   output logic              busy,
   output logic              cfg_err,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(P1_CYC - 1);
   localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(P2_CYC - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   pix_reg, pix_next;
   logic [CNT_W-1:0]   line_reg, line_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               oneshot_reg, oneshot_next;
   logic               cfg_err_reg, cfg_err_next;
   logic               load;

   logic [CNT_W-1:0]   width_reg, height_reg, hblank_reg, vblank_reg;
   logic [1:0]         pattern_reg;
   logic [DATA_W-1:0]  const_reg;

   logic [DATA_W-1:0]  idata_reg;
   logic               ifval_reg, ilval_reg, frame_start_reg, frame_done_reg, busy_reg;
   logic [FCNT_W-1:0]  frame_cnt_reg;

   logic               cfg_ok;
   logic [CNT_W-1:0]   hblank_last, vblank_last;
   logic [DATA_W-1:0]  pixel_val;
   logic               last_fend;

   assign cfg_ok      = (cfg_width != '0) && (cfg_height != '0);
   // Zero blanking collapses to a single cycle so lines and frames stay separated
   assign hblank_last = (hblank_reg == '0) ? '0 : hblank_reg - 1'b1;
   assign vblank_last = (vblank_reg == '0) ? '0 : vblank_reg - 1'b1;
   assign last_fend   = (state_reg == FEND) && (cnt_reg == P2_LAST);

   always_comb begin
      state_next   = state_reg;
      pix_next     = pix_reg;
      line_next    = line_reg;
      cnt_next     = cnt_reg;
      oneshot_next = oneshot_reg;
      cfg_err_next = cfg_err_reg;
      load         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable || single_shot) begin
               load         = cfg_ok;
               cfg_err_next = !cfg_ok;
               if (cfg_ok) begin
                  state_next   = FSTART;
                  cnt_next     = '0;
                  oneshot_next = !enable;
               end
            end
         end
         FSTART: begin
            if (cnt_reg == P1_LAST) begin
               state_next = LINE;
               pix_next   = '0;
               line_next  = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         LINE: begin
            if (pix_reg == width_reg - 1'b1) begin
               cnt_next   = '0;
               state_next = (line_reg == height_reg - 1'b1) ? FEND : HBLANK;
            end else begin
               pix_next = pix_reg + 1'b1;
            end
         end
         HBLANK: begin
            if (cnt_reg == hblank_last) begin
               state_next = LINE;
               pix_next   = '0;
               line_next  = line_reg + 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         FEND: begin
            if (cnt_reg == P2_LAST) begin
               state_next = VBLANK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         VBLANK: begin
            if (cnt_reg == vblank_last) begin
               if (enable && !oneshot_reg) begin
                  load         = cfg_ok;
                  cfg_err_next = !cfg_ok;
                  state_next   = cfg_ok ? FSTART : IDLE;
                  cnt_next     = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   d5m_pattern_gen #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_pattern (
      .pattern   (pattern_reg),
      .pix       (pix_reg),
      .line      (line_reg),
      .const_val (const_reg),
      .pixel     (pixel_val)
   );

   always_ff @(posedge pixclk) begin
      if (reset) begin
         state_reg       <= IDLE;
         pix_reg         <= '0;
         line_reg        <= '0;
         cnt_reg         <= '0;
         oneshot_reg     <= 1'b0;
         cfg_err_reg     <= 1'b0;
         width_reg       <= '0;
         height_reg      <= '0;
         hblank_reg      <= '0;
         vblank_reg      <= '0;
         pattern_reg     <= '0;
         const_reg       <= '0;
         idata_reg       <= '0;
         ifval_reg       <= 1'b0;
         ilval_reg       <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         frame_cnt_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         pix_reg     <= pix_next;
         line_reg    <= line_next;
         cnt_reg     <= cnt_next;
         oneshot_reg <= oneshot_next;
         cfg_err_reg <= cfg_err_next;
         if (load) begin
            width_reg   <= cfg_width;
            height_reg  <= cfg_height;
            hblank_reg  <= cfg_hblank;
            vblank_reg  <= cfg_vblank;
            pattern_reg <= cfg_pattern;
            const_reg   <= cfg_const;
         end
         // Bus outputs are a registered decode of the current state
         ifval_reg       <= (state_reg == FSTART) || (state_reg == LINE) ||
                            (state_reg == HBLANK) || (state_reg == FEND);
         ilval_reg       <= (state_reg == LINE);
         idata_reg       <= (state_reg == LINE) ? pixel_val : '0;
         frame_start_reg <= (state_reg == FSTART) && (cnt_reg == '0);
         frame_done_reg  <= last_fend;
         busy_reg        <= (state_reg != IDLE);
         frame_cnt_reg   <= frame_cnt_reg + FCNT_W'(last_fend);
      end
   end

   assign idata       = idata_reg;
   assign ifval       = ifval_reg;
   assign ilval       = ilval_reg;
   assign frame_start = frame_start_reg;
   assign frame_done  = frame_done_reg;
   assign busy        = busy_reg;
   assign cfg_err     = cfg_err_reg;
   assign frame_cnt   = frame_cnt_reg;

endmodule
